spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI mode-0 master (controller) that drives the serial link answered by the team's shift-register SPI peripheral.
- Accepts a parallel word and generates csN, sclk and mosi, MSB first.
- Samples miso into a parallel receive word.
- Sits between the test/host logic and the SPI memory peripheral. It is the initiating end of the same serial interface.

Parameters:
- WIDTH, 8, bits per transaction (≥2).
- CLK_DIV, 2, clk cycles per sclk half-period (≥1); sclk frequency = clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transaction; sampled only when idle.
- txData  input  WIDTH  word to transmit; captured at start acceptance.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when rxData is valid.
- rxData  output  WIDTH  last received word; holds until the next done.
- csN  output  1  chip select, active low.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  serial data to peripheral.
- miso  input  1  serial data from peripheral.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: csN=1, sclk=0, mosi=0, busy=0, done=0, rxData=0. Internal state goes to IDLE and the counters clear.
- Reset mid-transaction: on the next edge the block is idle with the reset values. No done pulse is generated.
- States: IDLE, SETUP, HIGH, LOW, TAIL.
- Timing reference: edge 0 is the clk edge at which start=1 is sampled in IDLE.
- Edge 0: go to SETUP.
  - csN=0, busy=1.
  - Transmit shift register loads txData.
  - mosi=txData[WIDTH-1].
  - Bit counter=0, divider=0.
- Divider: each state lasts exactly CLK_DIV cycles.
- Bit i, for i = 0..WIDTH-1:
  - sclk rises at edge CLK_DIV*(1+2i) (enter HIGH).
  - sclk falls at edge CLK_DIV*(2+2i) (enter LOW, or TAIL after the last bit).
- On each falling edge:
  - miso is shifted into the receive shift register LSB-first-in, i.e. rx <= {rx[WIDTH-2:0], miso}.
  - If i < WIDTH-1, the transmit register shifts left and mosi gets the next bit.
  - On the last bit, mosi holds its value.
  - The peripheral changes its output after the falling edge, so the sampled value is the bit presented during the high phase.
- TAIL: sclk=0 and csN=0 for CLK_DIV cycles.
- Edge CLK_DIV*(2*WIDTH+1):
  - csN=1, busy=0, mosi=0.
  - done=1 and rxData gets the receive register.
  - Go to IDLE.
- done drops to 0 on the following edge.
- start while busy (or during the done cycle) is ignored.
- txData changes after acceptance have no effect.
- Back-to-back: if start is held high, the next transaction is accepted on the edge after done. csN is therefore high for exactly 1 clk between transactions.
- Counter widths: the divider is sized by $clog2(CLK_DIV) and the bit counter by $clog2(WIDTH); there is no wrap beyond the terminal counts.

Test Plan:
1. Assert reset for 2 cycles with start=1 → csN=1, sclk=0, mosi=0, busy=0, done=0, rxData=8'h00; no transaction starts while reset=1.
2. Loopback: miso wired to mosi, CLK_DIV=2, txData=8'hA5, start pulsed for 1 cycle:
   - mosi bit sequence is 1,0,1,0,0,1,0,1 across 8 sclk pulses, each pulse 2 clk high and 2 low.
   - done is high at edge 34, rxData=8'hA5, busy low in the same cycle.
3. Bench drives miso=8'b11000011 MSB first, updating after each sclk falling edge, with txData=8'h00 → rxData=8'hC3, mosi stays 0 throughout.
4. start held high with txData=8'h3C, then 8'hF0, and start re-pulsed while busy:
   - Mid-transfer pulses are ignored.
   - The second transaction's csN falls exactly 1 clk after the first done.
   - Loopback rxData is 8'h3C, then 8'hF0.
5. reset asserted 1 cycle after the 3rd sclk rising edge of txData=8'hFF → next edge is idle, no done pulse; a subsequent txData=8'h0F transfer completes with loopback rxData=8'h0F.
6. CLK_DIV=1, WIDTH=8, txData=8'h81 with loopback → sclk period is 2 clk, done at edge 17, rxData=8'h81.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a parallel word out on mosi MSB first while
// sampling miso on each sclk falling edge into a parallel receive word.
module spi_master #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rxData,
    output logic             csN,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(WIDTH);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
    localparam logic [BitW-1:0] BitOne  = BitW'(1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StHigh  = 3'd2;
    localparam logic [2:0] StLow   = 3'd3;
    localparam logic [2:0] StTail  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [DivW-1:0]  div_q,     div_d;
    logic [BitW-1:0]  bit_q,     bit_d;
    logic [WIDTH-1:0] tx_q,      tx_d;
    logic [WIDTH-1:0] rx_q,      rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             cs_n_q,    cs_n_d;
    logic             sclk_q,    sclk_d;
    logic             mosi_q,    mosi_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic div_end;

    assign div_end = (div_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = txData;
                    mosi_d  = txData[WIDTH-1];
                    bit_d   = '0;
                    div_d   = '0;
                end
            end

            StSetup: begin
                if (div_end) begin
                    state_d = StHigh;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StHigh: begin
                if (div_end) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    rx_d   = {rx_q[WIDTH-2:0], miso};
                    if (bit_q == BitLast) begin
                        // Last bit: mosi keeps its value through the tail.
                        state_d = StTail;
                    end else begin
                        state_d = StLow;
                        bit_d   = bit_q + BitOne;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[WIDTH-2];
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StLow: begin
                if (div_end) begin
                    state_d = StHigh;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            StTail: begin
                if (div_end) begin
                    state_d   = StIdle;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    div_d     = '0;
                end else begin
                    div_d = div_q + DivOne;
                end
            end

            default: begin
                state_d = StIdle;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rxData = rx_data_q;
    assign csN    = cs_n_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single transfers on CLK_DIV=2 and
// CLK_DIV=1 instances, plus back-to-back and mid-transfer reset sequences.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] txData;
    logic       sel;
    logic       loop_en;
    logic       tb_miso;

    logic       busy0, done0, csN0, sclk0, mosi0, miso0;
    logic       busy1, done1, csN1, sclk1, mosi1, miso1;
    logic [7:0] rx0, rx1;

    logic       o_busy, o_done, o_csN, o_sclk, o_mosi;
    logic [7:0] o_rx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso0 = loop_en ? mosi0 : tb_miso;
    assign miso1 = loop_en ? mosi1 : tb_miso;

    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_csN  = sel ? csN1  : csN0;
    assign o_sclk = sel ? sclk1 : sclk0;
    assign o_mosi = sel ? mosi1 : mosi0;
    assign o_rx   = sel ? rx1   : rx0;

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start & ~sel),
        .txData (txData),
        .busy   (busy0),
        .done   (done0),
        .rxData (rx0),
        .csN    (csN0),
        .sclk   (sclk0),
        .mosi   (mosi0),
        .miso   (miso0)
    );

    spi_master #(.WIDTH(8), .CLK_DIV(1)) dut_fast (
        .clk    (clk),
        .reset  (reset),
        .start  (start & sel),
        .txData (txData),
        .busy   (busy1),
        .done   (done1),
        .rxData (rx1),
        .csN    (csN1),
        .sclk   (sclk1),
        .mosi   (mosi1),
        .miso   (miso1)
    );

    typedef struct {
        bit         fast;
        logic [7:0] tx;
        logic [7:0] pat;
        bit         loop;
        logic [7:0] exp_rx;
        int         exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows one transfer from just after edge 0 until done (or the budget expires).
    task automatic watch(input int cd, input bit loop, input logic [7:0] pat,
                         output int done_edge, output logic [7:0] mosi_seq,
                         output bit timing_ok, output bit frame_ok, output bit mosi_any);
        int   k;
        logic prev;
        k         = 0;
        prev      = 1'b0;
        done_edge = -1;
        mosi_seq  = '0;
        timing_ok = 1'b1;
        frame_ok  = 1'b1;
        mosi_any  = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (o_done) begin
                done_edge = e;
                break;
            end
            if (o_mosi) mosi_any = 1'b1;
            if (!o_busy || o_csN) frame_ok = 1'b0;
            if (!prev && o_sclk) begin
                if (k < 8) mosi_seq[7-k] = o_mosi;
                if (e != cd * (1 + 2 * k)) timing_ok = 1'b0;
            end
            if (prev && !o_sclk) begin
                if (e != cd * (2 + 2 * k)) timing_ok = 1'b0;
                k++;
                if (!loop && k < 8) tb_miso = pat[7-k];
            end
            prev = o_sclk;
        end
        if (k != 8) timing_ok = 1'b0;
    endtask

    task automatic finish_checks(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx,
                                 input int exp_done, input int done_edge,
                                 input logic [7:0] mosi_seq, input bit timing_ok,
                                 input bit frame_ok, input bit mosi_any);
        chk({tag, " done_edge"}, done_edge, exp_done);
        chk({tag, " rxData"}, o_rx, exp_rx);
        chk({tag, " busy_at_done"}, o_busy, 1'b0);
        chk({tag, " csN_at_done"}, o_csN, 1'b1);
        chk({tag, " mosi_at_done"}, o_mosi, 1'b0);
        chk({tag, " sclk_timing"}, timing_ok, 1'b1);
        chk({tag, " frame_busy_csN"}, frame_ok, 1'b1);
        chk({tag, " mosi_bits"}, mosi_seq, tx);
        chk({tag, " mosi_any"}, mosi_any, (tx != 8'h00));
    endtask

    task automatic run(input string tag, input bit fast, input logic [7:0] tx,
                       input logic [7:0] pat, input bit loop, input logic [7:0] exp_rx,
                       input int exp_done);
        int         de;
        logic [7:0] ms;
        bit         t_ok, f_ok, m_any;
        sel     = fast;
        loop_en = loop;
        tb_miso = pat[7];
        txData  = tx;
        start   = 1'b1;
        tick();
        start = 1'b0;
        watch(fast ? 1 : 2, loop, pat, de, ms, t_ok, f_ok, m_any);
        finish_checks(tag, tx, exp_rx, exp_done, de, ms, t_ok, f_ok, m_any);
        tick();
        chk({tag, " done_pulse_end"}, o_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         de;
        logic [7:0] ms;
        bit         t_ok, f_ok, m_any;
        bit         saw_done, saw_cs;

        vecs[0] = '{fast: 1'b0, tx: 8'hA5, pat: 8'h00, loop: 1'b1, exp_rx: 8'hA5, exp_done: 34};
        vecs[1] = '{fast: 1'b0, tx: 8'h00, pat: 8'hC3, loop: 1'b0, exp_rx: 8'hC3, exp_done: 34};
        vecs[2] = '{fast: 1'b0, tx: 8'hFF, pat: 8'h5A, loop: 1'b0, exp_rx: 8'h5A, exp_done: 34};
        vecs[3] = '{fast: 1'b0, tx: 8'h01, pat: 8'h80, loop: 1'b0, exp_rx: 8'h80, exp_done: 34};
        vecs[4] = '{fast: 1'b1, tx: 8'h81, pat: 8'h00, loop: 1'b1, exp_rx: 8'h81, exp_done: 17};

        sel     = 1'b0;
        loop_en = 1'b1;
        tb_miso = 1'b0;
        txData  = 8'hA5;
        start   = 1'b1;
        reset   = 1'b1;

        // Reset held with start high: nothing may begin.
        tick();
        tick();
        chk("reset csN", o_csN, 1'b1);
        chk("reset sclk", o_sclk, 1'b0);
        chk("reset mosi", o_mosi, 1'b0);
        chk("reset busy", o_busy, 1'b0);
        chk("reset done", o_done, 1'b0);
        chk("reset rxData", o_rx, 8'h00);
        chk("reset fast busy", busy1, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_reset csN", o_csN, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run($sformatf("vec%0d", i), vecs[i].fast, vecs[i].tx, vecs[i].pat, vecs[i].loop,
                vecs[i].exp_rx, vecs[i].exp_done);
        end

        // Back-to-back with start held; txData change and start re-pulse mid-transfer.
        sel     = 1'b0;
        loop_en = 1'b1;
        txData  = 8'h3C;
        start   = 1'b1;
        tick();
        txData = 8'hF0;
        fork
            watch(2, 1'b1, 8'h00, de, ms, t_ok, f_ok, m_any);
            begin
                repeat (5) @(posedge clk);
                #2 start = 1'b0;
                repeat (3) @(posedge clk);
                #2 start = 1'b1;
            end
        join
        finish_checks("b2b first", 8'h3C, 8'h3C, 34, de, ms, t_ok, f_ok, m_any);
        tick();
        chk("b2b restart csN", o_csN, 1'b0);
        chk("b2b restart busy", o_busy, 1'b1);
        chk("b2b restart done", o_done, 1'b0);
        start = 1'b0;
        watch(2, 1'b1, 8'h00, de, ms, t_ok, f_ok, m_any);
        finish_checks("b2b second", 8'hF0, 8'hF0, 34, de, ms, t_ok, f_ok, m_any);
        tick();

        // Reset one cycle after the third sclk rise (edge 10), taking effect at edge 12.
        sel     = 1'b0;
        loop_en = 1'b1;
        txData  = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("midreset sclk_before", o_sclk, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset csN", o_csN, 1'b1);
        chk("midreset sclk", o_sclk, 1'b0);
        chk("midreset mosi", o_mosi, 1'b0);
        chk("midreset busy", o_busy, 1'b0);
        chk("midreset done", o_done, 1'b0);
        chk("midreset rxData", o_rx, 8'h00);
        saw_done = 1'b0;
        saw_cs   = 1'b0;
        repeat (40) begin
            tick();
            if (o_done) saw_done = 1'b1;
            if (!o_csN) saw_cs = 1'b1;
        end
        chk("midreset no_done", saw_done, 1'b0);
        chk("midreset stays_idle", saw_cs, 1'b0);
        run("after_reset", 1'b0, 8'h0F, 8'h00, 1'b1, 8'h0F, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
